// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad front-end: key codes, FSM states and mode encodings.
package keypad_entry_pkg;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_BSP = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hC;

  localparam logic MODE_PIN = 1'b0;
  localparam logic MODE_AMT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad input and entry-result bundle; the keypad driver is the master, keypad_entry the slave.
interface keypad_entry_if #(
  parameter int PSW_DIGITS    = 4,
  parameter int BALANCE_WIDTH = 20
);
  logic                    key_valid;
  logic [3:0]              key_code;
  logic                    mode;
  logic [4*PSW_DIGITS-1:0] password_out;
  logic [BALANCE_WIDTH-1:0] value_out;
  logic                    entry_valid;
  logic                    entry_mode;
  logic [2:0]              digit_count;
  logic                    busy;
  logic                    entry_err;
  logic                    entry_abort;

  modport master (
    output key_valid, key_code, mode,
    input  password_out, value_out, entry_valid, entry_mode,
    input  digit_count, busy, entry_err, entry_abort
  );

  modport slave (
    input  key_valid, key_code, mode,
    output password_out, value_out, entry_valid, entry_mode,
    output digit_count, busy, entry_err, entry_abort
  );
endinterface

// File: rtl/keypad_entry_bcd_to_bin_seq.sv
// Multi-cycle decimal-to-binary converter: one BCD digit per cycle, MS digit first, acc = acc*10 + digit.
module bcd_to_bin_seq #(
  parameter int MAX_DIG = 6,
  parameter int BAL_W   = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*MAX_DIG-1:0] digits,
  input  logic [2:0]           count,
  output logic                 done,
  output logic [BAL_W-1:0]     acc
);

  logic [BAL_W-1:0] acc_q, acc_d;
  logic [2:0]       idx_q, idx_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  function automatic logic [BAL_W-1:0] nib_at(input logic [4*MAX_DIG-1:0] d, input logic [2:0] i);
    return BAL_W'(d[4*i +: 4]);
  endfunction

  function automatic logic [BAL_W-1:0] mul10(input logic [BAL_W-1:0] a);
    return (a << 3'd3) + (a << 3'd1);
  endfunction

  // The start cycle already folds in the first multiply-add from acc=0 (0*10 + MS digit).
  always_comb begin
    acc_d  = acc_q;
    idx_d  = idx_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      if (count == 3'd0) begin
        acc_d  = '0;
        idx_d  = 3'd0;
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        acc_d  = nib_at(digits, count - 3'd1);
        idx_d  = count - 3'd1;
        run_d  = (count != 3'd1);
        done_d = (count == 3'd1);
      end
    end else if (run_q) begin
      acc_d  = mul10(acc_q) + nib_at(digits, idx_q - 3'd1);
      idx_d  = idx_q - 3'd1;
      run_d  = (idx_q != 3'd1);
      done_d = (idx_q == 3'd1);
    end else begin
      run_d = 1'b0;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      idx_q  <= 3'd0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign acc  = acc_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry FSM and digit buffer producing a packed-BCD PIN or a binary amount.
// Optional inactivity abort in COLLECT is built when KEYPAD_TIMEOUT_EN is defined.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int PSW_DIGITS    = 4,
  parameter int VAL_DIGITS    = 6,
  parameter int BALANCE_WIDTH = 20,
  parameter int TIMEOUT_CYC   = 1000000
) (
  input logic         clk,
  input logic         rst,
  keypad_entry_if.slave kp
);

  localparam int MAX_DIG = max_int(PSW_DIGITS, VAL_DIGITS);
  localparam int BUF_W   = 4 * MAX_DIG;
  localparam int PW_W    = 4 * PSW_DIGITS;
  localparam logic [2:0] PSW_CNT = 3'(PSW_DIGITS);
  localparam logic [2:0] VAL_CNT = 3'(VAL_DIGITS);

  state_t                   state_q, state_d;
  logic [BUF_W-1:0]         buf_q, buf_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     mode_q, mode_d;
  logic [PW_W-1:0]          pw_q, pw_d;
  logic [BALANCE_WIDTH-1:0] val_q, val_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;
  logic                     conv_start;
  logic                     conv_done;
  logic [BALANCE_WIDTH-1:0] conv_acc;
  logic [2:0]               cnt_max;

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            abort_q, abort_d;
`endif

  bcd_to_bin_seq #(.MAX_DIG(MAX_DIG), .BAL_W(BALANCE_WIDTH)) u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (conv_start),
    .digits (buf_q),
    .count  (cnt_q),
    .done   (conv_done),
    .acc    (conv_acc)
  );

  assign cnt_max = (mode_q == MODE_AMT) ? VAL_CNT : PSW_CNT;

  // Next-state, buffer and result logic; results are loaded on the edge that enters DONE.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    pw_d       = pw_q;
    val_d      = val_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    conv_start = 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
    to_d       = to_q;
    abort_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (kp.key_valid && is_digit(kp.key_code)) begin
          mode_d  = kp.mode;
          buf_d   = BUF_W'(kp.key_code);
          cnt_d   = 3'd1;
          state_d = ST_COLLECT;
`ifdef KEYPAD_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (kp.key_valid) begin
`ifdef KEYPAD_TIMEOUT_EN
          to_d = '0;
`endif
          if (is_digit(kp.key_code)) begin
            if (cnt_q < cnt_max) begin
              buf_d = {buf_q[BUF_W-5:0], kp.key_code};
              cnt_d = cnt_q + 3'd1;
            end else begin
              cnt_d = cnt_q;
            end
          end else if (kp.key_code == KEY_BSP) begin
            buf_d = buf_q >> 3'd4;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_COLLECT;
            end
          end else if (kp.key_code == KEY_CLR) begin
            buf_d   = '0;
            cnt_d   = 3'd0;
            state_d = ST_IDLE;
          end else if (kp.key_code == KEY_ENT) begin
            if (mode_q == MODE_PIN) begin
              if (cnt_q == PSW_CNT) begin
                pw_d    = buf_q[PW_W-1:0];
                valid_d = 1'b1;
                state_d = ST_DONE;
              end else begin
                err_d = 1'b1;
              end
            end else if (cnt_q == 3'd0) begin
              err_d = 1'b1;
            end else begin
              conv_start = 1'b1;
              state_d    = ST_CONVERT;
            end
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
`ifdef KEYPAD_TIMEOUT_EN
          if (to_q == TO_MAX) begin
            abort_d = 1'b1;
            buf_d   = '0;
            cnt_d   = 3'd0;
            state_d = ST_IDLE;
          end else begin
            to_d = to_q + 1'b1;
          end
`else
          state_d = ST_COLLECT;
`endif
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          val_d   = conv_acc;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_CONVERT;
        end
      end
      ST_DONE: begin
        cnt_d   = 3'd0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_COLLECT) || (state_d == ST_CONVERT);
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= 3'd0;
      mode_q  <= 1'b0;
      pw_q    <= '0;
      val_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pw_q    <= pw_d;
      val_q   <= val_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

`ifdef KEYPAD_TIMEOUT_EN
  // Inactivity counter and abort strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      to_q    <= to_d;
      abort_q <= abort_d;
    end
  end
  assign kp.entry_abort = abort_q;
`else
  assign kp.entry_abort = 1'b0;
`endif

  assign kp.password_out = pw_q;
  assign kp.value_out    = val_q;
  assign kp.entry_valid  = valid_q;
  assign kp.entry_mode   = mode_q;
  assign kp.digit_count  = cnt_q;
  assign kp.busy         = busy_q;
  assign kp.entry_err    = err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: stimulus pushes expected events, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_keypad_entry;
  import keypad_entry_pkg::*;

  typedef struct {
    int          kind;   // 0 = entry_valid, 1 = entry_err, 2 = entry_abort
    logic [15:0] pw;
    logic [19:0] val;
    logic        md;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   nvec  = 0;
  int   nfail = 0;
  int   last  = 0;
  exp_t sbq[$];
  exp_t mon_e;
  int   got_kind;
  logic [15:0] m_pw  = 16'h0;
  logic [19:0] m_val = 20'h0;

  keypad_entry_if #(.PSW_DIGITS(4), .BALANCE_WIDTH(20)) kp();

  keypad_entry #(
    .PSW_DIGITS(4), .VAL_DIGITS(6), .BALANCE_WIDTH(20), .TIMEOUT_CYC(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    @(posedge clk); #1;
    kp.key_valid = 1'b1;
    kp.key_code  = c;
    @(posedge clk); #1;
    kp.key_valid = 1'b0;
    last = cyc;
  endtask

  // lat counts cycles from the enter cycle to the strobe (1 = the cycle right after it).
  task automatic expect_evt(input int kind, input logic md, input int lat);
    exp_t e;
    e.kind = kind; e.pw = m_pw; e.val = m_val; e.md = md; e.at = last + lat - 1;
    sbq.push_back(e);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_password_out", 32'(kp.password_out), 32'h0);
    chk("rst_value_out",    32'(kp.value_out),    32'h0);
    chk("rst_entry_valid",  32'(kp.entry_valid),  32'h0);
    chk("rst_entry_mode",   32'(kp.entry_mode),   32'h0);
    chk("rst_digit_count",  32'(kp.digit_count),  32'h0);
    chk("rst_busy",         32'(kp.busy),         32'h0);
    chk("rst_entry_err",    32'(kp.entry_err),    32'h0);
    chk("rst_entry_abort",  32'(kp.entry_abort),  32'h0);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (kp.entry_valid || kp.entry_err || kp.entry_abort)) begin
      got_kind = kp.entry_valid ? 0 : (kp.entry_err ? 1 : 2);
      if (sbq.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_strobe: valid=%0b err=%0b abort=%0b with empty scoreboard (cycle %0d)",
                 kp.entry_valid, kp.entry_err, kp.entry_abort, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("strobe_kind",  32'(got_kind), 32'(mon_e.kind));
        chk("strobe_cycle", 32'(cyc),      32'(mon_e.at));
        if (mon_e.kind == 0) begin
          chk("password_out", 32'(kp.password_out), 32'(mon_e.pw));
          chk("value_out",    32'(kp.value_out),    32'(mon_e.val));
          chk("entry_mode",   32'(kp.entry_mode),   32'(mon_e.md));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    kp.key_valid = 1'b0;
    kp.key_code  = 4'h0;
    kp.mode      = 1'b0;
    #2;
    chk_reset_outputs();
    idle(3);
    rst = 1'b0;
    idle(1);

    // Control and ignored codes in IDLE do nothing.
    press(KEY_ENT); press(KEY_BSP); press(4'hD);
    idle(1);
    chk("idle_ignore_busy",  32'(kp.busy),        32'h0);
    chk("idle_ignore_count", 32'(kp.digit_count), 32'h0);

    // 1: PIN 1234 with a mid-entry mode change and an ignored code.
    kp.mode = 1'b0;
    press(4'd1);
    kp.mode = 1'b1;
    press(4'd2); press(4'hE); press(4'd3); press(4'd4);
    chk("pin_count4", 32'(kp.digit_count), 32'd4);
    press(KEY_ENT);
    m_pw = 16'h1234;
    expect_evt(0, 1'b0, 1);
    idle(2);
    chk("pin_done_busy",  32'(kp.busy),        32'h0);
    chk("pin_done_count", 32'(kp.digit_count), 32'h0);

    // 2: amount 250; key during CONVERT ignored.
    kp.mode = 1'b1;
    press(4'd2);
    chk("amt_busy_first_key", 32'(kp.busy), 32'h1);
    press(4'd5); press(4'd0);
    press(KEY_ENT);
    m_val = 20'd250;
    expect_evt(0, 1'b1, 4);
    press(4'd7);
    chk("amt_busy_convert",  32'(kp.busy),        32'h1);
    chk("amt_count_convert", 32'(kp.digit_count), 32'd3);
    idle(2);
    chk("amt_done_busy",  32'(kp.busy),        32'h0);
    chk("amt_done_count", 32'(kp.digit_count), 32'h0);

    // 3: seven 9s, seventh dropped; 999999.
    kp.mode = 1'b1;
    for (int i = 0; i < 7; i++) press(4'd9);
    chk("max_count6", 32'(kp.digit_count), 32'd6);
    press(KEY_ENT);
    m_val = 20'hF423F;
    expect_evt(0, 1'b1, 7);
    idle(9);

    // 5: backspace to empty, clear, then edit to 1298.
    kp.mode = 1'b0;
    press(4'd5); press(KEY_BSP);
    chk("bsp_count0", 32'(kp.digit_count), 32'h0);
    chk("bsp_idle",   32'(kp.busy),        32'h0);
    press(KEY_BSP);
    chk("bsp_in_idle_count", 32'(kp.digit_count), 32'h0);
    press(4'd7); press(KEY_CLR);
    chk("clr_count0", 32'(kp.digit_count), 32'h0);
    chk("clr_idle",   32'(kp.busy),        32'h0);
    press(4'd1); press(4'd2); press(4'd3); press(KEY_BSP); press(4'd9); press(4'd8);
    press(KEY_ENT);
    m_pw = 16'h1298;
    expect_evt(0, 1'b0, 1);
    idle(2);

    // 4: short PIN rejected, digits kept, then completed.
    kp.mode = 1'b0;
    press(4'd1); press(4'd2); press(KEY_ENT);
    expect_evt(1, 1'b0, 1);
    idle(1);
    chk("err_count_kept", 32'(kp.digit_count), 32'd2);
    chk("err_busy",       32'(kp.busy),        32'h1);
    press(4'd3); press(4'd4); press(KEY_ENT);
    m_pw = 16'h1234;
    expect_evt(0, 1'b0, 1);
    idle(2);

    // 6a: inactivity in COLLECT.
    kp.mode = 1'b0;
    press(4'd3);
`ifdef KEYPAD_TIMEOUT_EN
    expect_evt(2, 1'b0, 17);
    idle(20);
    chk("abort_count0", 32'(kp.digit_count), 32'h0);
    chk("abort_idle",   32'(kp.busy),        32'h0);
`else
    idle(40);
    chk("no_timeout_busy",  32'(kp.busy),        32'h1);
    chk("no_timeout_count", 32'(kp.digit_count), 32'd1);
    press(KEY_CLR);
    idle(1);
`endif

    // 6b: reset in the middle of CONVERT abandons the entry.
    kp.mode = 1'b1;
    press(4'd9); press(4'd9); press(4'd9); press(KEY_ENT);
    idle(1);
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    m_pw  = 16'h0;
    m_val = 20'h0;
    idle(3);
    rst = 1'b0;
    idle(8);

    // Recovery after reset: PIN 4321 with value_out still 0.
    kp.mode = 1'b0;
    press(4'd4); press(4'd3); press(4'd2); press(4'd1); press(KEY_ENT);
    m_pw = 16'h4321;
    expect_evt(0, 1'b0, 1);
    idle(5);

    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
